// File: rtl/uart_parity_frame_checker.sv
// UART frame checker: assembles LSB-first data bits, checks parity and stop bits, and keeps sticky errors.
// Define PARITY_ERR_CNT_EN to add the 8-bit saturating errored-frame counter on err_cnt.
module uart_parity_frame_checker #(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              parity_bit_error,
    output logic              frame_error,
    output logic              parity_err_sticky,
    output logic              frame_err_sticky
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              frame_done;
    logic [DATA_W-1:0] data_out_q;
    logic              fvalid_q, perr_out_q, ferr_out_q;
    logic              psticky_q, fsticky_q;

    function automatic logic expected_parity(input logic acc);
        case (PARITY_MODE)
            1:       return ~acc;
            2:       return acc;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // frame_start restarts from any state and takes priority over a coincident bit
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = DATA;
        end else if (bit_valid) begin
            case (state_q)
                DATA: begin
                    if (cnt_q == LAST_DATA) begin
                        state_d = (PARITY_MODE == 0) ? STOP : PARITY;
                    end
                end
                PARITY:  state_d = STOP;
                STOP: begin
                    if (cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        if (frame_start) begin
            shift_d = '0;
            cnt_d   = '0;
            acc_d   = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                DATA: begin
                    shift_d = {bit_in, shift_q[DATA_W-1:1]};
                    acc_d   = acc_q ^ bit_in;
                    cnt_d   = (cnt_q == LAST_DATA) ? '0 : cnt_q + CNT_W'(1);
                end
                PARITY: begin
                    perr_d = (bit_in != expected_parity(acc_q));
                end
                STOP: begin
                    if (!bit_in) begin
                        ferr_d = 1'b1;
                    end
                    if (cnt_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame results and sticky flags; a sticky set beats a same-cycle err_clr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_out_q <= '0;
            fvalid_q   <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            psticky_q  <= 1'b0;
            fsticky_q  <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            fvalid_q <= frame_done;
            if (frame_done) begin
                data_out_q <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_d;
            end
            if (frame_done && perr_q) begin
                psticky_q <= 1'b1;
            end else if (err_clr) begin
                psticky_q <= 1'b0;
            end
            if (frame_done && ferr_d) begin
                fsticky_q <= 1'b1;
            end else if (err_clr) begin
                fsticky_q <= 1'b0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        err_cnt_d = err_clr ? 8'd0 : err_cnt_q;
        if (frame_done && (perr_q || ferr_d)) begin
            err_cnt_d = sat_inc8(err_cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign data_out          = data_out_q;
    assign frame_valid       = fvalid_q;
    assign parity_bit_error  = perr_out_q;
    assign frame_error       = ferr_out_q;
    assign parity_err_sticky = psticky_q;
    assign frame_err_sticky  = fsticky_q;

endmodule

// File: tb/tb_uart_parity_frame_checker.sv
// Bench for uart_parity_frame_checker: five parameterisations share one stimulus stream and are
// compared every cycle against a bit-counting frame model, plus literal checks of known frames.
module tb_uart_parity_frame_checker;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst_n, frame_start, bit_valid, bit_in, err_clr;

    logic       g_fv [NI];
    logic       g_pe [NI];
    logic       g_fe [NI];
    logic       g_ps [NI];
    logic       g_fs [NI];
    logic [8:0] dout [NI];
    logic [7:0] g_cnt [NI];
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [6:0] d3;
    logic [8:0] d4;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit fv_cnt_en = 1'b0;
    int fv_cnt = 0;

    always #5 clk = ~clk;

    function automatic int dw_of(int k);
        case (k)
            2:       return 5;
            3:       return 7;
            4:       return 9;
            default: return 8;
        endcase
    endfunction

    function automatic int pm_of(int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 0;
            3:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int sb_of(int k);
        return (k == 1 || k == 4) ? 2 : 1;
    endfunction

    uart_parity_frame_checker #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clr(err_clr), .data_out(d0), .frame_valid(g_fv[0]), .parity_bit_error(g_pe[0]),
        .frame_error(g_fe[0]), .parity_err_sticky(g_ps[0]), .frame_err_sticky(g_fs[0])
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(g_cnt[0])
`endif
    );
    uart_parity_frame_checker #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clr(err_clr), .data_out(d1), .frame_valid(g_fv[1]), .parity_bit_error(g_pe[1]),
        .frame_error(g_fe[1]), .parity_err_sticky(g_ps[1]), .frame_err_sticky(g_fs[1])
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(g_cnt[1])
`endif
    );
    uart_parity_frame_checker #(.DATA_W(5), .PARITY_MODE(0), .STOP_BITS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clr(err_clr), .data_out(d2), .frame_valid(g_fv[2]), .parity_bit_error(g_pe[2]),
        .frame_error(g_fe[2]), .parity_err_sticky(g_ps[2]), .frame_err_sticky(g_fs[2])
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(g_cnt[2])
`endif
    );
    uart_parity_frame_checker #(.DATA_W(7), .PARITY_MODE(4), .STOP_BITS(1)) u3 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clr(err_clr), .data_out(d3), .frame_valid(g_fv[3]), .parity_bit_error(g_pe[3]),
        .frame_error(g_fe[3]), .parity_err_sticky(g_ps[3]), .frame_err_sticky(g_fs[3])
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(g_cnt[3])
`endif
    );
    uart_parity_frame_checker #(.DATA_W(9), .PARITY_MODE(3), .STOP_BITS(2)) u4 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .err_clr(err_clr), .data_out(d4), .frame_valid(g_fv[4]), .parity_bit_error(g_pe[4]),
        .frame_error(g_fe[4]), .parity_err_sticky(g_ps[4]), .frame_err_sticky(g_fs[4])
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(g_cnt[4])
`endif
    );

    assign dout[0] = {1'b0, d0};
    assign dout[1] = {1'b0, d1};
    assign dout[2] = {4'b0, d2};
    assign dout[3] = {2'b0, d3};
    assign dout[4] = d4;

    task automatic chk(input string nm, input int k, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, got, exp);
        end
    endtask

    // Reference model: count bits since frame_start, judge the frame once it has enough bits.
    bit         m_act [NI];
    int         m_n   [NI];
    bit         m_bits[NI][16];
    bit         e_fv  [NI];
    bit         e_pe  [NI];
    bit         e_fe  [NI];
    bit         e_ps  [NI];
    bit         e_fs  [NI];
    logic [8:0] e_data[NI];
    int         e_cnt [NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit done, pe, fe;
            int ones, dw, pm, sb;
            done = 1'b0; pe = 1'b0; fe = 1'b0;
            dw = dw_of(k); pm = pm_of(k); sb = sb_of(k);
            if (!rst_n) begin
                m_act[k] = 1'b0; m_n[k] = 0; e_fv[k] = 1'b0; e_pe[k] = 1'b0; e_fe[k] = 1'b0;
                e_ps[k] = 1'b0; e_fs[k] = 1'b0; e_data[k] = '0; e_cnt[k] = 0;
            end else begin
                e_fv[k] = 1'b0;
                if (frame_start) begin
                    m_act[k] = 1'b1;
                    m_n[k] = 0;
                end else if (bit_valid && m_act[k]) begin
                    m_bits[k][m_n[k]] = bit_in;
                    m_n[k]++;
                    if (m_n[k] == dw + (pm != 0 ? 1 : 0) + sb) begin
                        m_act[k] = 1'b0;
                        done = 1'b1;
                    end
                end
                if (done) begin
                    ones = 0;
                    e_data[k] = '0;
                    for (int i = 0; i < dw; i++) begin
                        e_data[k][i] = m_bits[k][i];
                        ones += int'(m_bits[k][i]);
                    end
                    case (pm)
                        1: pe = ((ones + int'(m_bits[k][dw])) % 2) != 1;
                        2: pe = ((ones + int'(m_bits[k][dw])) % 2) != 0;
                        3: pe = m_bits[k][dw] != 1'b1;
                        4: pe = m_bits[k][dw] != 1'b0;
                        default: pe = 1'b0;
                    endcase
                    for (int s = 0; s < sb; s++)
                        if (!m_bits[k][dw + (pm != 0 ? 1 : 0) + s]) fe = 1'b1;
                    e_fv[k] = 1'b1;
                    e_pe[k] = pe;
                    e_fe[k] = fe;
                end
                if (pe) e_ps[k] = 1'b1;
                else if (err_clr) e_ps[k] = 1'b0;
                if (fe) e_fs[k] = 1'b1;
                else if (err_clr) e_fs[k] = 1'b0;
                if (err_clr) e_cnt[k] = 0;
                if (pe || fe) e_cnt[k] = (e_cnt[k] < 255) ? e_cnt[k] + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                chk("frame_valid", k, 9'(g_fv[k]), 9'(e_fv[k]));
                chk("data_out", k, dout[k], e_data[k]);
                chk("parity_bit_error", k, 9'(g_pe[k]), 9'(e_pe[k]));
                chk("frame_error", k, 9'(g_fe[k]), 9'(e_fe[k]));
                chk("parity_err_sticky", k, 9'(g_ps[k]), 9'(e_ps[k]));
                chk("frame_err_sticky", k, 9'(g_fs[k]), 9'(e_fs[k]));
`ifdef PARITY_ERR_CNT_EN
                chk("err_cnt", k, 9'(g_cnt[k]), 9'(e_cnt[k]));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (fv_cnt_en && g_fv[0]) fv_cnt++;
    end

    // Inputs change at negedge; each call returns at the negedge after the sampling edge.
    task automatic send_bit(input logic b, input logic clr);
        bit_valid = 1'b1; bit_in = b; err_clr = clr;
        @(negedge clk);
        bit_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i], 1'b0);
    endtask

    task automatic start_pulse();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int nb;
        rst_n = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_frame_valid", 0, 9'(g_fv[0]), 9'd0);
        chk("rst_data_out", 0, dout[0], 9'd0);
        chk("rst_psticky", 0, 9'(g_ps[0]), 9'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 0xA5, parity 0, stops 1,1: clean for even/1-stop, parity error for odd/2-stop
        v = 32'h6A5;
        start_pulse();
        send_bits(v, 10);
        chk("a5_fv", 0, 9'(g_fv[0]), 9'd1);
        chk("a5_data", 0, dout[0], 9'h0A5);
        chk("a5_perr", 0, 9'(g_pe[0]), 9'd0);
        chk("a5_ferr", 0, 9'(g_fe[0]), 9'd0);
        send_bits(v >> 10, 1);
        chk("a5_odd_fv", 1, 9'(g_fv[1]), 9'd1);
        chk("a5_odd_perr", 1, 9'(g_pe[1]), 9'd1);
        chk("a5_odd_psticky", 1, 9'(g_ps[1]), 9'd1);
        repeat (2) @(negedge clk);

        // 0xA5 with parity 1: even-parity error, then err_clr
        v = 32'h7A5;
        start_pulse();
        send_bits(v, 10);
        chk("a5p1_perr", 0, 9'(g_pe[0]), 9'd1);
        chk("a5p1_psticky", 0, 9'(g_ps[0]), 9'd1);
`ifdef PARITY_ERR_CNT_EN
        chk("a5p1_cnt", 0, 9'(g_cnt[0]), 9'd1);
`endif
        send_bits(v >> 10, 1);
        @(negedge clk);
        chk("a5p1_held_perr", 0, 9'(g_pe[0]), 9'd1);
        clr_pulse();
        chk("clr_psticky", 0, 9'(g_ps[0]), 9'd0);
`ifdef PARITY_ERR_CNT_EN
        chk("clr_cnt", 0, 9'(g_cnt[0]), 9'd0);
`endif

        // err_clr in the same cycle as an errored frame completes: set wins
        start_pulse();
        send_bits(v, 9);
        send_bit(1'b1, 1'b1);
        chk("setclr_psticky", 0, 9'(g_ps[0]), 9'd1);
`ifdef PARITY_ERR_CNT_EN
        chk("setclr_cnt", 0, 9'(g_cnt[0]), 9'd1);
`endif
        send_bits(v >> 10, 1);
        clr_pulse();

        // 0x3C, odd parity 1, stops 1,0 on the two-stop-bit instance
        v = 32'h33C;
        start_pulse();
        send_bits(v, 11);
        chk("3c_fv", 1, 9'(g_fv[1]), 9'd1);
        chk("3c_data", 1, dout[1], 9'h03C);
        chk("3c_perr", 1, 9'(g_pe[1]), 9'd0);
        chk("3c_ferr", 1, 9'(g_fe[1]), 9'd1);
        chk("3c_fsticky", 1, 9'(g_fs[1]), 9'd1);
        repeat (2) @(negedge clk);

        // Abort after 3 data bits, then a full 0x81 frame
        fv_cnt = 0; fv_cnt_en = 1'b1;
        start_pulse();
        send_bits(32'h5, 3);
        start_pulse();
        send_bits(32'h681, 11);
        repeat (3) @(negedge clk);
        fv_cnt_en = 1'b0;
        chk("abort_fv_count", 0, 9'(fv_cnt), 9'd1);
        chk("abort_data", 0, dout[0], 9'h081);

        // Reset mid-DATA: nothing completes afterwards, all outputs cleared
        fv_cnt = 0; fv_cnt_en = 1'b1;
        start_pulse();
        send_bits(32'hF, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_data", 0, dout[0], 9'd0);
        chk("midrst_fsticky", 1, 9'(g_fs[1]), 9'd0);
        chk("midrst_fv", 0, 9'(g_fv[0]), 9'd0);
        send_bits(32'h7F, 7);
        repeat (3) @(negedge clk);
        fv_cnt_en = 1'b0;
        chk("midrst_fv_count", 0, 9'(fv_cnt), 9'd0);

        // frame_start with bit_valid: the bit must be discarded
        frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; bit_valid = 1'b0;
        send_bits(32'h600, 10);
        chk("simul_fv", 0, 9'(g_fv[0]), 9'd1);
        chk("simul_data", 0, dout[0], 9'd0);
        send_bits(32'h1, 1);
        repeat (2) @(negedge clk);

        // Randomised frames: lengths, gaps, aborts, clears and resets
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 99) < 3) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            frame_start = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                bit_valid = 1'b1;
                bit_in = 1'($urandom);
            end
            @(negedge clk);
            frame_start = 1'b0; bit_valid = 1'b0;
            nb = $urandom_range(4, 13);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send_bit(1'($urandom), 1'($urandom_range(0, 15) == 0));
            end
            if ($urandom_range(0, 7) == 0) clr_pulse();
        end

`ifdef PARITY_ERR_CNT_EN
        // 300 errored frames saturate the counter
        clr_pulse();
        for (int i = 0; i < 300; i++) begin
            start_pulse();
            send_bits(32'h7A5, 11);
        end
        @(negedge clk);
        chk("sat_cnt", 0, 9'(g_cnt[0]), 9'd255);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_parity_frame_checker.md
UART_PARITY_FRAME_CHECKER -- requirements
Module: uart_parity_frame_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY_MODE, default 2, parity mode: 0 none, 1 odd, 2 even, 3 mark, 4 space.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked (legal 1..2).
REQ-004 SHALL use one clock and a synchronous, active-low reset; there SHALL be no other clock or reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port frame_start, input, 1 bit: single-cycle pulse from the RX FSM; start bit detected.
REQ-008 SHALL have port bit_valid, input, 1 bit: qualifies bit_in as one mid-bit sample.
REQ-009 SHALL have port bit_in, input, 1 bit: sampled serial bit, LSB first.
REQ-010 SHALL have port err_clr, input, 1 bit: clears the sticky flags and the error counter.
REQ-011 SHALL have port data_out, output, DATA_W bits: last received data word.
REQ-012 SHALL have port frame_valid, output, 1 bit: one-cycle pulse; frame result available.
REQ-013 SHALL have port parity_bit_error, output, 1 bit: parity mismatch in the last frame.
REQ-014 SHALL have port frame_error, output, 1 bit: a stop bit was sampled as 0 in the last frame.
REQ-015 SHALL have port parity_err_sticky, output, 1 bit, and port frame_err_sticky, output, 1 bit: sticky error status.

Function
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: bit_valid SHALL be ignored; frame_start SHALL clear the shift register, bit count and parity accumulator, then go to DATA.
REQ-018 DATA: each bit_valid SHALL shift bit_in into the word LSB-first and XOR it into the accumulator; after DATA_W bits go to PARITY, or to STOP if PARITY_MODE=0.
REQ-019 PARITY: on bit_valid, the expected bit SHALL be ~acc (odd), acc (even), 1 (mark) or 0 (space); record a mismatch, then go to STOP.
REQ-020 STOP: each bit_valid SHALL record an error if bit_in=0; after STOP_BITS bits, return to IDLE.
REQ-021 In the cycle after the edge that samples the final stop bit, frame_valid SHALL be 1 and data_out, parity_bit_error and frame_error SHALL be updated together.
REQ-022 data_out, parity_bit_error and frame_error SHALL hold until the next frame_valid.
REQ-023 frame_start outside IDLE SHALL abort the frame (no frame_valid) and restart in DATA.
REQ-024 When frame_start and bit_valid are asserted in the same cycle, frame_start SHALL win and the bit SHALL be discarded.
REQ-025 parity_bit_error SHALL always be 0 when PARITY_MODE=0.
REQ-026 Sticky flags SHALL set when frame_valid occurs with the corresponding error.
REQ-027 err_clr SHALL clear both sticky flags.
REQ-028 If a sticky set and err_clr occur in the same cycle, the set SHALL win.

Reset
REQ-029 On rst_n=0 at a clock edge, the FSM SHALL go to IDLE and every output, counter and internal register SHALL go to 0.
REQ-030 A reset mid-frame SHALL discard the frame; no frame_valid SHALL follow.

Configuration
REQ-031 Macro PARITY_ERR_CNT_EN defined: the block SHALL add output err_cnt, 8 bits.
REQ-032 With PARITY_ERR_CNT_EN defined, err_cnt SHALL increment once per frame_valid with any error, saturate at 255, and be zeroed by err_clr.
REQ-033 With PARITY_ERR_CNT_EN defined, increment and err_clr in the same cycle SHALL yield 1.
REQ-034 Macro PARITY_ERR_CNT_EN undefined: the port and the counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-035 Defaults; frame 0xA5, parity 0, stop 1 -> frame_valid 1 cycle after the stop bit, data_out=0xA5, both errors 0.
REQ-036 Defaults; 0xA5 with parity 1 -> parity_bit_error=1, parity_err_sticky=1, err_cnt=1; then err_clr -> sticky=0, err_cnt=0.
REQ-037 STOP_BITS=2; 0x3C, correct parity, stops 1,0 -> frame_error=1, frame_err_sticky=1, data_out=0x3C.
REQ-038 Abort and simultaneous events: frame_start after 3 data bits, then a full 0x81 frame -> exactly one frame_valid, data_out=0x81.
REQ-039 Abort and simultaneous events: frame_start with bit_valid in the same cycle -> bit discarded.
REQ-040 Reset and saturation: rst_n low mid-DATA -> no frame_valid and all outputs 0; 300 parity-error frames (PARITY_ERR_CNT_EN defined) -> err_cnt=255.
